// File: rtl/axi4_lite_addr_fanout_pkg.sv
// axi4_lite_addr_fanout_pkg
// Shared types, response codes and the address decoder for the AXI4-Lite
// 1-to-2 address fanout.
// Optional feature macro: AXI4_LITE_FANOUT_DECERR_EN. When defined,
// addresses at or above twice the window size decode to no port.
package axi4_lite_addr_fanout_pkg;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // sel picks the downstream port; err means no port claims the address.
  typedef struct packed {
    logic err;
    logic sel;
  } route_t;

  // Addresses are zero-extended to 64 bits so one function serves any A.
  function automatic route_t decode(input logic [63:0] addr, input logic [63:0] win);
    route_t r;
    r.sel = (addr >= win);
`ifdef AXI4_LITE_FANOUT_DECERR_EN
    r.err = (addr >= (win << 1));
`else
    r.err = 1'b0;
`endif
    return r;
  endfunction

endpackage

// File: rtl/axi4_if.sv
// axi4_if
// AXI4 bus bundle (AW/W/B/AR/R). The fanout drives AXI4-Lite traffic over it
// and ties the burst-related fields to single-beat values.
// Parameters: A address bits, N data bytes, I ID bits.
// Modports: master (drives requests), slave (answers requests).
interface axi4_if #(
  parameter int A = 16,
  parameter int N = 4,
  parameter int I = 1
);
  logic [I-1:0]   awid;
  logic [A-1:0]   awaddr;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic           awlock;
  logic [3:0]     awcache;
  logic [2:0]     awprot;
  logic [3:0]     awqos;
  logic [3:0]     awregion;
  logic           awvalid;
  logic           awready;
  logic [N*8-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wlast;
  logic           wvalid;
  logic           wready;
  logic [I-1:0]   bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic [I-1:0]   arid;
  logic [A-1:0]   araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arlock;
  logic [3:0]     arcache;
  logic [2:0]     arprot;
  logic [3:0]     arqos;
  logic [3:0]     arregion;
  logic           arvalid;
  logic           arready;
  logic [I-1:0]   rid;
  logic [N*8-1:0] rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_lite_addr_fanout_wr.sv
// axi4_lite_addr_fanout_wr
// Write-path FSM of the fanout. Collects upstream AW and W in either order,
// replays them to the selected downstream port, then passes B straight back.
// Ports: s_* upstream AW/W/B; aw_*/w_* registered request fields shared by
// both downstream ports; m_* per-port downstream valid/ready/response [1:0].
// alive is the registered out-of-reset flag that gates upstream readies.
// Optional feature macro: AXI4_LITE_FANOUT_DECERR_EN (answers unmapped
// writes locally with DECERR).
module axi4_lite_addr_fanout_wr
  import axi4_lite_addr_fanout_pkg::*;
#(
  parameter int A = 16,
  parameter int N = 4,
  parameter int M = 'h0100,
  parameter int I = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 alive,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [A-1:0]         s_awaddr,
  input  logic [I-1:0]         s_awid,
  input  logic [2:0]           s_awprot,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  input  logic [N*8-1:0]       s_wdata,
  input  logic [N-1:0]         s_wstrb,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  output logic [1:0]           s_bresp,
  output logic [I-1:0]         s_bid,
  output logic [A-1:0]         aw_addr,
  output logic [I-1:0]         aw_id,
  output logic [2:0]           aw_prot,
  output logic [N*8-1:0]       w_data,
  output logic [N-1:0]         w_strb,
  output logic [1:0]           m_awvalid,
  input  logic [1:0]           m_awready,
  output logic [1:0]           m_wvalid,
  input  logic [1:0]           m_wready,
  input  logic [1:0]           m_bvalid,
  output logic [1:0]           m_bready,
  input  logic [1:0][1:0]      m_bresp,
  input  logic [1:0][I-1:0]    m_bid
);

  wr_state_t state_q, state_d;
  // aw_held/w_held: in W_IDLE "captured from upstream", in W_REQ "still owed
  // downstream". Both are clear again by the time W_RESP is reached.
  logic   aw_held, w_held;
  logic   sel_q, err_q;
  logic   aw_hs, w_hs, aw_have, w_have, aw_left, w_left;
  route_t route;

  assign aw_hs   = s_awvalid & s_awready;
  assign w_hs    = s_wvalid & s_wready;
  assign aw_have = aw_held | aw_hs;
  assign w_have  = w_held | w_hs;
  assign aw_left = aw_held & ~m_awready[sel_q];
  assign w_left  = w_held & ~m_wready[sel_q];
  // Decode the address arriving this cycle so the last upstream handshake
  // can move straight to W_REQ.
  assign route   = decode(64'(aw_hs ? s_awaddr : aw_addr), 64'(M));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= W_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: default every always_comb output first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE: if (aw_have && w_have) state_d = route.err ? W_RESP : W_REQ;
      W_REQ:  if (!aw_left && !w_left) state_d = W_RESP;
      W_RESP: if (s_bvalid && s_bready) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // NOTE: the request registers are ordinary flops, not a memory array, so
  // they are reset to 0 like the control state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      aw_addr <= '0;
      aw_id   <= '0;
      aw_prot <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      unique case (state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            aw_addr <= s_awaddr;
            aw_id   <= s_awid;
            aw_prot <= s_awprot;
          end
          if (w_hs) begin
            w_held <= 1'b1;
            w_data <= s_wdata;
            w_strb <= s_wstrb;
          end
          if (aw_have && w_have) begin
            sel_q <= route.sel;
            err_q <= route.err;
            // Unmapped: nothing is owed downstream.
            if (route.err) begin
              aw_held <= 1'b0;
              w_held  <= 1'b0;
            end
          end
        end
        W_REQ: begin
          aw_held <= aw_left;
          w_held  <= w_left;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_awready = alive & (state_q == W_IDLE) & ~aw_held;
    s_wready  = alive & (state_q == W_IDLE) & ~w_held;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    s_bid     = aw_id;
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    unique case (state_q)
      W_REQ: begin
        m_awvalid[sel_q] = aw_held;
        m_wvalid[sel_q]  = w_held;
      end
      W_RESP: begin
        if (err_q) begin
          s_bvalid = 1'b1;
          s_bresp  = RESP_DECERR;
        end else begin
          s_bvalid        = m_bvalid[sel_q];
          s_bresp         = m_bresp[sel_q];
          s_bid           = m_bid[sel_q];
          m_bready[sel_q] = s_bready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axi4_lite_addr_fanout.sv
// axi4_lite_addr_fanout
// AXI4-Lite 1-to-2 address-decoding fanout. Addresses below M go to
// axi4_m[0], addresses M and above to axi4_m[1]; fields pass unmodified.
// One outstanding transaction per direction; read and write run concurrently.
// Ports: aclk, aresetn (async active-low), axi4_s (upstream, slave modport),
// axi4_m[2] (downstream, master modport).
// Optional feature macro: AXI4_LITE_FANOUT_DECERR_EN (addresses >= 2*M are
// answered locally with DECERR and never reach a downstream port).
module axi4_lite_addr_fanout
  import axi4_lite_addr_fanout_pkg::*;
#(
  parameter int A = 16,
  parameter int N = 4,
  parameter int M = 'h0100,
  parameter int I = 1
) (
  input logic     aclk,
  input logic     aresetn,
  axi4_if.slave   axi4_s,
  axi4_if.master  axi4_m [2]
);

  localparam int DW = N * 8;

  logic alive;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) alive <= 1'b0;
    else          alive <= 1'b1;
  end

  logic [1:0]          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0][1:0]     m_bresp, m_rresp;
  logic [1:0][I-1:0]   m_bid, m_rid;
  logic [1:0][DW-1:0]  m_rdata;
  logic [A-1:0]        aw_addr, ar_addr;
  logic [I-1:0]        aw_id, ar_id;
  logic [2:0]          aw_prot, ar_prot;
  logic [DW-1:0]       w_data;
  logic [N-1:0]        w_strb;

  axi4_lite_addr_fanout_wr #(.A(A), .N(N), .M(M), .I(I)) u_wr (
    .aclk(aclk), .aresetn(aresetn), .alive(alive),
    .s_awvalid(axi4_s.awvalid), .s_awready(axi4_s.awready), .s_awaddr(axi4_s.awaddr),
    .s_awid(axi4_s.awid), .s_awprot(axi4_s.awprot),
    .s_wvalid(axi4_s.wvalid), .s_wready(axi4_s.wready), .s_wdata(axi4_s.wdata),
    .s_wstrb(axi4_s.wstrb),
    .s_bvalid(axi4_s.bvalid), .s_bready(axi4_s.bready), .s_bresp(axi4_s.bresp),
    .s_bid(axi4_s.bid),
    .aw_addr(aw_addr), .aw_id(aw_id), .aw_prot(aw_prot), .w_data(w_data), .w_strb(w_strb),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid)
  );

  // Read path
  rd_state_t     rd_q, rd_d;
  logic          rd_sel, rd_err, ar_hs;
  logic          s_arready, s_rvalid;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic [I-1:0]  s_rid;
  route_t        ar_route;

  assign ar_hs    = axi4_s.arvalid & s_arready;
  assign ar_route = decode(64'(axi4_s.araddr), 64'(M));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_q <= R_IDLE;
    else          rd_q <= rd_d;
  end

  always_comb begin
    rd_d = rd_q;
    unique case (rd_q)
      R_IDLE: if (ar_hs) rd_d = ar_route.err ? R_RESP : R_REQ;
      R_REQ:  if (m_arready[rd_sel]) rd_d = R_RESP;
      R_RESP: if (s_rvalid && axi4_s.rready) rd_d = R_IDLE;
      default: rd_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_addr <= '0;
      ar_id   <= '0;
      ar_prot <= '0;
      rd_sel  <= 1'b0;
      rd_err  <= 1'b0;
    end else if (rd_q == R_IDLE && ar_hs) begin
      ar_addr <= axi4_s.araddr;
      ar_id   <= axi4_s.arid;
      ar_prot <= axi4_s.arprot;
      rd_sel  <= ar_route.sel;
      rd_err  <= ar_route.err;
    end
  end

  always_comb begin
    s_arready = alive & (rd_q == R_IDLE);
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = RESP_OKAY;
    s_rid     = ar_id;
    m_arvalid = '0;
    m_rready  = '0;
    unique case (rd_q)
      R_REQ: m_arvalid[rd_sel] = 1'b1;
      R_RESP: begin
        if (rd_err) begin
          s_rvalid = 1'b1;
          s_rresp  = RESP_DECERR;
        end else begin
          s_rvalid         = m_rvalid[rd_sel];
          s_rdata          = m_rdata[rd_sel];
          s_rresp          = m_rresp[rd_sel];
          s_rid            = m_rid[rd_sel];
          m_rready[rd_sel] = axi4_s.rready;
        end
      end
      default: ;
    endcase
  end

  assign axi4_s.arready = s_arready;
  assign axi4_s.rvalid  = s_rvalid;
  assign axi4_s.rdata   = s_rdata;
  assign axi4_s.rresp   = s_rresp;
  assign axi4_s.rid     = s_rid;
  assign axi4_s.rlast   = 1'b1;

  // Both downstream ports share the request fields; only valid/ready differ.
  for (genvar g = 0; g < 2; g++) begin : g_port
    assign axi4_m[g].awid     = aw_id;
    assign axi4_m[g].awaddr   = aw_addr;
    assign axi4_m[g].awlen    = 8'd0;
    assign axi4_m[g].awsize   = 3'($clog2(N));
    assign axi4_m[g].awburst  = BURST_INCR;
    assign axi4_m[g].awlock   = 1'b0;
    assign axi4_m[g].awcache  = 4'd0;
    assign axi4_m[g].awprot   = aw_prot;
    assign axi4_m[g].awqos    = 4'd0;
    assign axi4_m[g].awregion = 4'd0;
    assign axi4_m[g].awvalid  = m_awvalid[g];
    assign axi4_m[g].wdata    = w_data;
    assign axi4_m[g].wstrb    = w_strb;
    assign axi4_m[g].wlast    = 1'b1;
    assign axi4_m[g].wvalid   = m_wvalid[g];
    assign axi4_m[g].bready   = m_bready[g];
    assign axi4_m[g].arid     = ar_id;
    assign axi4_m[g].araddr   = ar_addr;
    assign axi4_m[g].arlen    = 8'd0;
    assign axi4_m[g].arsize   = 3'($clog2(N));
    assign axi4_m[g].arburst  = BURST_INCR;
    assign axi4_m[g].arlock   = 1'b0;
    assign axi4_m[g].arcache  = 4'd0;
    assign axi4_m[g].arprot   = ar_prot;
    assign axi4_m[g].arqos    = 4'd0;
    assign axi4_m[g].arregion = 4'd0;
    assign axi4_m[g].arvalid  = m_arvalid[g];
    assign axi4_m[g].rready   = m_rready[g];

    assign m_awready[g] = axi4_m[g].awready;
    assign m_wready[g]  = axi4_m[g].wready;
    assign m_bvalid[g]  = axi4_m[g].bvalid;
    assign m_bresp[g]   = axi4_m[g].bresp;
    assign m_bid[g]     = axi4_m[g].bid;
    assign m_arready[g] = axi4_m[g].arready;
    assign m_rvalid[g]  = axi4_m[g].rvalid;
    assign m_rdata[g]   = axi4_m[g].rdata;
    assign m_rresp[g]   = axi4_m[g].rresp;
    assign m_rid[g]     = axi4_m[g].rid;
  end

endmodule

// File: tb/tb_axi4_lite_addr_fanout.sv
// tb_axi4_lite_addr_fanout
// Drives the upstream port, models two downstream register files, and
// checks routing and responses through expectation queues.
// Inputs change 1 ns after the rising edge; everything is sampled on the
// falling edge. Compile with AXI4_LITE_FANOUT_DECERR_EN for the DECERR case.
module tb_axi4_lite_addr_fanout;
  import axi4_lite_addr_fanout_pkg::*;

  localparam int A = 16;
  localparam int N = 4;
  localparam int M = 'h0100;
  localparam int I = 1;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_if #(.A(A), .N(N), .I(I)) s_if ();
  axi4_if #(.A(A), .N(N), .I(I)) m_if [2] ();

  axi4_lite_addr_fanout #(.A(A), .N(N), .M(M), .I(I)) dut (
    .aclk(aclk), .aresetn(aresetn), .axi4_s(s_if), .axi4_m(m_if)
  );

  typedef struct { int port; logic [A-1:0] addr; logic [31:0] data; } dw_t;
  typedef struct { int port; logic [A-1:0] addr; } dar_t;
  typedef struct { logic [1:0] resp; logic [I-1:0] id; logic [31:0] data; } rsp_t;

  dw_t  exp_dw[$];
  dar_t exp_ar[$];
  rsp_t exp_b[$];
  rsp_t exp_r[$];
  int   checks = 0;
  int   errors = 0;
  bit   stall[2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Upstream B/R monitors
  rsp_t eb, er;
  always @(negedge aclk) begin
    if (aresetn && s_if.bvalid && s_if.bready) begin
      if (exp_b.size() == 0) check("b_unexpected", 64'(s_if.bresp), 64'hB0);
      else begin
        eb = exp_b.pop_front();
        check("bresp", 64'(s_if.bresp), 64'(eb.resp));
        check("bid", 64'(s_if.bid), 64'(eb.id));
      end
    end
  end

  always @(negedge aclk) begin
    if (aresetn && s_if.rvalid && s_if.rready) begin
      if (exp_r.size() == 0) check("r_unexpected", 64'(s_if.rdata), 64'hF0);
      else begin
        er = exp_r.pop_front();
        check("rdata", 64'(s_if.rdata), 64'(er.data));
        check("rresp", 64'(s_if.rresp), 64'(er.resp));
        check("rid", 64'(s_if.rid), 64'(er.id));
        check("rlast", 64'(s_if.rlast), 64'd1);
      end
    end
  end

  // Downstream subordinate models: port 0 always ready, port 1 ready every
  // other cycle so held valids are exercised.
  for (genvar g = 0; g < 2; g++) begin : g_sub
    logic [31:0]  mem [logic [A-1:0]];
    logic         got_aw, got_w, awhs, whs, bhs, arhs, rhs, tog;
    logic [A-1:0] a_q, ar_a;
    logic [31:0]  d_q;
    logic [I-1:0] id_q, ar_id;
    dw_t          ed;
    dar_t         ea;

    initial begin
      m_if[g].awready = 1'b0; m_if[g].wready = 1'b0; m_if[g].arready = 1'b0;
      m_if[g].bvalid = 1'b0; m_if[g].bresp = 2'b00; m_if[g].bid = '0;
      m_if[g].rvalid = 1'b0; m_if[g].rdata = '0; m_if[g].rresp = 2'b00;
      m_if[g].rid = '0; m_if[g].rlast = 1'b1;
      got_aw = 1'b0; got_w = 1'b0; tog = 1'b0;
      a_q = '0; d_q = '0; id_q = '0; ar_a = '0; ar_id = '0;
      forever begin
        @(negedge aclk);
        awhs = m_if[g].awvalid & m_if[g].awready;
        whs  = m_if[g].wvalid & m_if[g].wready;
        bhs  = m_if[g].bvalid & m_if[g].bready;
        arhs = m_if[g].arvalid & m_if[g].arready;
        rhs  = m_if[g].rvalid & m_if[g].rready;
        if (awhs) begin a_q = m_if[g].awaddr; id_q = m_if[g].awid; end
        if (whs) d_q = m_if[g].wdata;
        if (arhs) begin ar_a = m_if[g].araddr; ar_id = m_if[g].arid; end
        @(posedge aclk);
        #1;
        if (!aresetn) begin
          got_aw = 1'b0; got_w = 1'b0;
          m_if[g].bvalid = 1'b0; m_if[g].rvalid = 1'b0;
          m_if[g].awready = 1'b0; m_if[g].wready = 1'b0; m_if[g].arready = 1'b0;
        end else begin
          if (awhs) got_aw = 1'b1;
          if (whs) got_w = 1'b1;
          if (bhs) m_if[g].bvalid = 1'b0;
          if (got_aw && got_w) begin
            if (exp_dw.size() == 0) check("dw_unexpected", 64'(a_q), 64'hFFFF_0000);
            else begin
              ed = exp_dw.pop_front();
              check("dw_port", 64'(g), 64'(ed.port));
              check("dw_awaddr", 64'(a_q), 64'(ed.addr));
              check("dw_wdata", 64'(d_q), 64'(ed.data));
            end
            mem[a_q] = d_q;
            m_if[g].bvalid = 1'b1; m_if[g].bresp = RESP_OKAY; m_if[g].bid = id_q;
            got_aw = 1'b0; got_w = 1'b0;
          end
          if (rhs) m_if[g].rvalid = 1'b0;
          if (arhs) begin
            if (exp_ar.size() == 0) check("ar_unexpected", 64'(ar_a), 64'hFFFF_0000);
            else begin
              ea = exp_ar.pop_front();
              check("ar_port", 64'(g), 64'(ea.port));
              check("ar_addr", 64'(ar_a), 64'(ea.addr));
            end
            m_if[g].rvalid = 1'b1; m_if[g].rresp = RESP_OKAY; m_if[g].rid = ar_id;
            m_if[g].rdata = mem.exists(ar_a) ? mem[ar_a] : 32'hDEAD_0000 + 32'(g);
          end
          tog = ~tog;
          m_if[g].awready = !stall[g] && (g == 0 || tog);
          m_if[g].wready  = !stall[g] && (g == 0 || tog);
          m_if[g].arready = !stall[g] && (g == 0 || tog);
        end
      end
    end
  end

  task automatic do_write(input logic [A-1:0] addr, input logic [31:0] data,
                          input logic [I-1:0] id, input int port, input logic [1:0] resp,
                          input int w_lead, input int b_hold);
    bit awhs, whs, aw_done, w_done, bdone, seen, dropped, leak;
    int cyc, held;
    exp_b.push_back('{resp, id, 32'h0});
    if (port >= 0) exp_dw.push_back('{port, addr, data});
    @(posedge aclk);
    #1;
    s_if.awaddr = addr; s_if.awid = id; s_if.awprot = 3'd0;
    s_if.wdata = data; s_if.wstrb = '1; s_if.wvalid = 1'b1;
    s_if.awvalid = (w_lead == 0);
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge aclk);
      awhs = s_if.awvalid && s_if.awready;
      whs  = s_if.wvalid && s_if.wready;
      @(posedge aclk);
      #1;
      cyc++;
      if (awhs) begin s_if.awvalid = 1'b0; aw_done = 1'b1; end
      if (whs) begin s_if.wvalid = 1'b0; w_done = 1'b1; end
      if (!aw_done && cyc >= w_lead) s_if.awvalid = 1'b1;
    end
    check("aw_w_accepted", 64'({aw_done, w_done}), 64'b11);
    s_if.bready = (b_hold == 0);
    held = 0; seen = 1'b0; dropped = 1'b0; leak = 1'b0; bdone = 1'b0; cyc = 0;
    while (!bdone && cyc < 50) begin
      @(negedge aclk);
      if (s_if.bvalid && s_if.bready) bdone = 1'b1;
      else if (s_if.bvalid) begin seen = 1'b1; held++; end
      else if (seen) dropped = 1'b1;
      if (!bdone && s_if.awready) leak = 1'b1;
      @(posedge aclk);
      #1;
      cyc++;
      if (held >= b_hold) s_if.bready = 1'b1;
    end
    s_if.bready = 1'b0;
    check("b_done", 64'(bdone), 64'd1);
    check("aw_blocked_until_b", 64'(leak), 64'd0);
    if (b_hold > 0) check("bvalid_stable", 64'(dropped), 64'd0);
  endtask

  task automatic do_read(input logic [A-1:0] addr, input logic [I-1:0] id, input int port,
                         input logic [31:0] data, input logic [1:0] resp);
    bit hs, ar_done, r_done;
    int cyc;
    exp_r.push_back('{resp, id, data});
    if (port >= 0) exp_ar.push_back('{port, addr});
    @(posedge aclk);
    #1;
    s_if.araddr = addr; s_if.arid = id; s_if.arprot = 3'd0; s_if.arvalid = 1'b1;
    ar_done = 1'b0; cyc = 0;
    while (!ar_done && cyc < 50) begin
      @(negedge aclk);
      hs = s_if.arvalid && s_if.arready;
      @(posedge aclk);
      #1;
      cyc++;
      if (hs) begin s_if.arvalid = 1'b0; ar_done = 1'b1; end
    end
    s_if.rready = 1'b1;
    r_done = 1'b0; cyc = 0;
    while (!r_done && cyc < 50) begin
      @(negedge aclk);
      hs = s_if.rvalid && s_if.rready;
      @(posedge aclk);
      #1;
      cyc++;
      if (hs) r_done = 1'b1;
    end
    s_if.rready = 1'b0;
    check("read_done", 64'({ar_done, r_done}), 64'b11);
  endtask

  function automatic logic [13:0] all_handshake_bits();
    return {s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid,
            m_if[0].awvalid, m_if[0].wvalid, m_if[0].arvalid, m_if[0].bready, m_if[0].rready,
            m_if[1].awvalid, m_if[1].wvalid, m_if[1].arvalid, m_if[1].bready};
  endfunction

  initial begin
    s_if.awvalid = 1'b0; s_if.awaddr = '0; s_if.awid = '0; s_if.awprot = '0;
    s_if.awlen = '0; s_if.awsize = 3'd2; s_if.awburst = BURST_INCR; s_if.awlock = 1'b0;
    s_if.awcache = '0; s_if.awqos = '0; s_if.awregion = '0;
    s_if.wvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b1;
    s_if.bready = 1'b0;
    s_if.arvalid = 1'b0; s_if.araddr = '0; s_if.arid = '0; s_if.arprot = '0;
    s_if.arlen = '0; s_if.arsize = 3'd2; s_if.arburst = BURST_INCR; s_if.arlock = 1'b0;
    s_if.arcache = '0; s_if.arqos = '0; s_if.arregion = '0;
    s_if.rready = 1'b0;

    // Reset state
    #12;
    check("reset_idle", 64'(all_handshake_bits()), 64'd0);
    check("reset_m1_rready", 64'(m_if[1].rready), 64'd0);
    #10 aresetn = 1'b1;
    @(negedge aclk);
    check("awready_after_reset", 64'(s_if.awready), 64'd1);
    check("arready_after_reset", 64'(s_if.arready), 64'd1);

    // Window 0 write/read, then window 1 write and reads of both
    do_write(16'h0004, 32'hABBA_BEEF, 1'b0, 0, RESP_OKAY, 0, 0);
    do_read (16'h0004, 1'b0, 0, 32'hABBA_BEEF, RESP_OKAY);
    do_write(16'h0104, 32'h1234_5678, 1'b1, 1, RESP_OKAY, 0, 0);
    do_read (16'h0004, 1'b1, 0, 32'hABBA_BEEF, RESP_OKAY);
    do_read (16'h0104, 1'b0, 1, 32'h1234_5678, RESP_OKAY);

    // Window boundary: M-N and M
    do_write(16'h00FC, 32'h0000_00FC, 1'b0, 0, RESP_OKAY, 0, 0);
    do_write(16'h0100, 32'h0000_0100, 1'b1, 1, RESP_OKAY, 0, 0);
    do_read (16'h00FC, 1'b1, 0, 32'h0000_00FC, RESP_OKAY);
    do_read (16'h0100, 1'b0, 1, 32'h0000_0100, RESP_OKAY);

    // W leads AW by 3 cycles, bready held low for 5 bvalid cycles
    do_write(16'h0010, 32'hCAFE_F00D, 1'b1, 0, RESP_OKAY, 3, 5);
    do_read (16'h0010, 1'b0, 0, 32'hCAFE_F00D, RESP_OKAY);

    // Reset while the write sits in W_REQ
    stall[0] = 1'b1;
    @(posedge aclk);
    #1;
    s_if.awaddr = 16'h0008; s_if.awid = '0; s_if.wdata = 32'h0BAD_0BAD; s_if.wstrb = '1;
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    @(negedge aclk);
    check("wreq_awvalid_m0", 64'(m_if[0].awvalid), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    check("async_reset_idle", 64'(all_handshake_bits()), 64'd0);
    stall[0] = 1'b0;
    @(posedge aclk);
    #3 aresetn = 1'b1;
    #1;
    check("awready_before_clock", 64'(s_if.awready), 64'd0);
    @(posedge aclk);
    #1;
    check("awready_first_clock", 64'(s_if.awready), 64'd1);

    // Addresses at or above 2*M
`ifdef AXI4_LITE_FANOUT_DECERR_EN
    do_write(16'h0200, 32'h5555_AAAA, 1'b1, -1, RESP_DECERR, 0, 0);
    do_read (16'h0200, 1'b1, -1, 32'h0000_0000, RESP_DECERR);
`else
    do_write(16'h0200, 32'h5555_AAAA, 1'b1, 1, RESP_OKAY, 0, 0);
    do_read (16'h0200, 1'b1, 1, 32'h5555_AAAA, RESP_OKAY);
`endif

    repeat (4) @(posedge aclk);
    check("queues_drained", 64'(exp_dw.size() + exp_ar.size() + exp_b.size() + exp_r.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_addr_fanout.md
# axi4_lite_addr_fanout

AXI4-Lite 1-to-2 address-decoding fanout. One upstream AXI4-Lite manager port, the slave-side `axi4_s`, is routed to one of two downstream subordinate ports, `axi4_m[0]` and `axi4_m[1]`, according to the transaction address. It sits between a bus master and a pair of register files or peripherals that each occupy an M-byte window.

## Interface
- `A`, default 16: address width in bits.
- `N`, default 4: data bus width in bytes; data width is N*8.
- `M`, default 'h0100: window size in bytes; must be a power of two.
- `I`, default 1: ID width in bits.
- `aclk`  in  1: the only clock.
- `aresetn`  in  1: asynchronous, active-low reset.
- `axi4_s`  slave modport of `axi4_if #(A,N)`  —: upstream port with channels AW/W/B/AR/R (addr A, data N*8, strb N, id I, resp 2).
- `axi4_m[2]`  master modport of `axi4_if #(A,N)`  —: downstream ports.

## Operation
- Decode: `sel = (addr >= M)`. Addresses 0 to M-1 go to `m[0]`; addresses M and above go to `m[1]`.
- Address, ID, prot, data and strb are forwarded unmodified; no offset is subtracted.
- Each direction allows one outstanding transaction. The read and write paths run independently and concurrently.
- Write FSM:
  - W_IDLE: `awready=1` until AW is captured and `wready=1` until W is captured. AW and W are accepted in any order or in the same cycle, and their fields are registered. When both are held, latch `sel` and go to W_REQ.
  - W_REQ: drive `m[sel].awvalid` and `m[sel].wvalid` from the registers. Each drops independently on its own handshake. When both handshakes are done, go to W_RESP.
  - W_RESP: pass through combinationally `s.bvalid/bresp/bid = m[sel].*` and `m[sel].bready = s.bready`. On the `s` B handshake, go to W_IDLE.
- Read FSM:
  - R_IDLE: `arready=1`. On handshake, register addr/id/prot and `sel`, then go to R_REQ.
  - R_REQ: drive `m[sel].arvalid` until `arready`, then go to R_RESP.
  - R_RESP: pass through R (`rvalid/rdata/rresp/rid`, `rlast=1`) and `rready`. On handshake, go to R_IDLE.
- The non-selected port always sees valid=0 and ready=0.
- Unused AXI4 full signals: len=0, size=$clog2(N), burst=INCR, cache/qos/region/lock/user=0, wlast=1.

## Timing
- Reset state: both FSMs idle. All valid and ready outputs on every port are 0 while `aresetn` is low; data/addr registers are 0.
- Readies are gated by a registered out-of-reset flag, so they rise on the first `aclk` after deassertion.
- Latency from the upstream AW+W handshake (last of the two) to downstream `awvalid/wvalid`: 1 cycle.
- Latency from the upstream AR handshake to `m.arvalid`: 1 cycle.
- Responses pass through with 0 cycles of latency.
- Once asserted, a valid is held stable until its handshake.
- Backpressure (`bready`/`rready` low) holds the FSM in RESP indefinitely. No new AW/W/AR is accepted in that direction meanwhile.
- Reset asserted mid-transaction abandons it immediately; all valids drop asynchronously.
- Boundary: M-N maps to `m[0]` and M maps to `m[1]`.

## Configuration
- `AXI4_LITE_FANOUT_DECERR_EN`.
- Defined: addresses >= 2*M select no port. The block itself answers with a 1-cycle-later B response (bresp=2'b11) or R response (rresp=2'b11, rdata=0, rid echoed), and downstream valids stay 0.
- Undefined: all addresses >= M go to `m[1]`.

## Structure
- Package `axi4_lite_addr_fanout_pkg` holds:
  - the `wr_state_t` (W_IDLE/W_REQ/W_RESP) and `rd_state_t` (R_IDLE/R_REQ/R_RESP) enums;
  - `RESP_OKAY=2'b00` and `RESP_DECERR=2'b11`;
  - the `decode(addr)` function.
- Sub-module `axi4_lite_addr_fanout_wr` holds the write-path FSM. The read path is inline in the top.

## Test plan
- Write 0x0004 = 0xABBA_BEEF, then read 0x0004. Require `m[0]` sees awaddr 0x0004 and wdata 0xABBABEEF, `m[1]` sees no valid, bresp=0, and rdata=0xABBABEEF.
- Write 0x0104 = 0x1234_5678, then read 0x0004 and 0x0104. Require the transaction is routed to `m[1]` with awaddr 0x0104, and the reads return 0xABBABEEF and 0x12345678 respectively.
- Boundary: accesses to 0x00FC and 0x0100 must route to `m[0]` and `m[1]` respectively.
- W presented 3 cycles before AW, and `bready` held low 5 cycles. Require a single downstream write; `bvalid` held 5 cycles; no AW accepted until the B handshake.
- Assert `aresetn`=0 while in W_REQ. Require all valids and readies go to 0 immediately and `awready=1` on the first clock after release.
- With `AXI4_LITE_FANOUT_DECERR_EN` defined, write 0x0200 and read 0x0200. Require bresp=2'b11, rresp=2'b11, rdata=0, and no downstream valid.
